// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet parameter loader: default frame geometry
// and the loader FSM state encoding.
package maxnet_pkg;

    localparam int DATA_W = 32;
    localparam int N      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        LOAD_W = 2'd2,
        READY  = 2'd3
    } state_t;

endpackage

// File: rtl/maxnet_word_regfile.sv
// Word-addressed register file with one write port, a flat parallel read
// and asynchronous clear.
module maxnet_word_regfile #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DEPTH*DATA_W-1:0] rdata_flat
);

    logic [DEPTH*DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            regs[addr*DATA_W +: DATA_W] <= wdata;
        end
    end

    assign rdata_flat = regs;

endmodule

// File: rtl/maxnet_param_loader.sv
// Loads one MaxNet frame (N activations, then N*N row-major weights) from a
// valid/ready word stream and presents it in parallel with framing checks.
module maxnet_param_loader #(
    parameter int DATA_W = maxnet_pkg::DATA_W,
    parameter int N      = maxnet_pkg::N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  compute_busy,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [N*DATA_W-1:0]   x_flat,
    output logic [N*N*DATA_W-1:0] w_flat,
    output logic                  data_valid,
    output logic                  done,
    output logic                  err
);

    import maxnet_pkg::*;

    localparam int NW    = N * N;
    localparam int IDX_W = $clog2(NW);
    localparam int XA_W  = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             data_valid_n, done_n, err_n;
    logic             x_we, w_we;
    logic             xfer;

    assign in_ready = (state == LOAD_X) || (state == LOAD_W);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            data_valid <= data_valid_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

    // The offending word of a bad frame is still written; only the state,
    // err and done reflect the framing failure.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        data_valid_n = data_valid;
        done_n       = 1'b0;
        err_n        = err;
        x_we         = 1'b0;
        w_we         = 1'b0;
        unique case (state)
            IDLE, READY: begin
                if (start && !compute_busy) begin
                    state_n      = LOAD_X;
                    idx_n        = '0;
                    data_valid_n = 1'b0;
                    err_n        = 1'b0;
                end
            end
            LOAD_X: begin
                if (xfer) begin
                    x_we = 1'b1;
                    if (in_last) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        err_n   = 1'b1;
                    end else if (idx == IDX_W'(N - 1)) begin
                        state_n = LOAD_W;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    w_we = 1'b1;
                    if (idx == IDX_W'(NW - 1)) begin
                        idx_n = '0;
                        if (in_last) begin
                            state_n      = READY;
                            done_n       = 1'b1;
                            data_valid_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end else if (in_last) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    maxnet_word_regfile #(
        .DEPTH  (N),
        .DATA_W (DATA_W)
    ) u_x_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (x_we),
        .addr       (idx[XA_W-1:0]),
        .wdata      (in_data),
        .rdata_flat (x_flat)
    );

    maxnet_word_regfile #(
        .DEPTH  (NW),
        .DATA_W (DATA_W)
    ) u_w_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (w_we),
        .addr       (idx),
        .wdata      (in_data),
        .rdata_flat (w_flat)
    );

endmodule
